// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   Parametrised 32-bit-wide data memory for the single-cycle MIPS datapath.
//   Supports byte/halfword/word loads and stores on little-endian byte
//   lanes, sign/zero extension of narrow loads, alignment checking with a
//   one-cycle misaligned pulse, and a post-reset sequencer that zeroes
//   every word before requests are accepted.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high
//   mem_read     load request this cycle
//   mem_write    store request this cycle
//   size         00 byte, 01 halfword, 10 word, 11 illegal
//   is_unsigned  loads only: 1 = zero-extend, 0 = sign-extend
//   address      byte address (upper bits beyond the array are ignored)
//   write_data   store data, right-justified
//   read_data    registered load result (holds when no legal load)
//   ready        requests are accepted only while high
//   misaligned   one-cycle pulse after an accepted illegal/misaligned request
module data_memory_bytelane #(
    parameter int unsigned ADDR_W         = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        misaligned
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clear_idx;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       old_word;
    logic [31:0]       shifted;
    logic              accept;
    logic              legal;
    logic [3:0]        byte_en;
    logic [31:0]       lane_data;
    logic [31:0]       load_val;
    logic              unused_addr;

    // Upper address bits are deliberately ignored so the array wraps.
    assign unused_addr = ^address[31:ADDR_W+2];

    assign word_idx = address[ADDR_W+1:2];
    assign old_word = mem[word_idx];
    assign ready    = (state == IDLE) && !reset;
    assign accept   = ready && (mem_read || mem_write);

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else                state <= IDLE;
            clear_idx <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) clear_idx <= clear_idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clear_idx == '1) next_state = IDLE;
            IDLE:    next_state = IDLE;
            default: next_state = CLEAR;
        endcase
    end

    // ---------------- request decode ----------------
    always_comb begin
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = !address[0];
            2'b10:   legal = (address[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes; the byte enables pick
    // which lanes actually land in the word.
    always_comb begin
        byte_en   = '0;
        lane_data = write_data;
        case (size)
            2'b00: begin
                byte_en   = 4'b0001 << address[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en   = address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                lane_data = write_data;
            end
            default: byte_en = '0;
        endcase
    end

    assign shifted = old_word >> {address[1:0], 3'b000};

    always_comb begin
        load_val = old_word;
        case (size)
            2'b00: load_val = is_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_val = is_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = old_word;
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clear_idx] <= '0;
            end else if (accept && legal && mem_write) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if (byte_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

    // Read samples the pre-write word, giving read-before-write on a
    // combined read+write request.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data  <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= accept && !legal;
            if (accept && legal && mem_read) read_data <= load_val;
        end
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    data_memory_bytelane #(
        .ADDR_W(5),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .size(size),
        .is_unsigned(is_unsigned),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_mis = exp_mis;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        mem_read = 1'b0; mem_write = 1'b0; size = W; is_unsigned = 1'b0;
        address = '0; write_data = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        mem_read = v.rd; mem_write = v.wr; size = v.sz; is_unsigned = v.uns;
        address = v.addr; write_data = v.wd;
        sb.push_back('{rd: v.exp_rd, mis: v.exp_mis, idx: idx});
        @(posedge clk); #1;
        drive_idle();
        e = sb.pop_front();
        chk($sformatf("vec%0d read_data", e.idx), read_data, e.rd);
        chk($sformatf("vec%0d misaligned", e.idx), {31'b0, misaligned}, {31'b0, e.mis});
    endtask

    // Counts cycles after reset release until ready rises (bounded).
    task automatic wait_ready(input string name);
        int cnt;
        cnt = 0;
        while (!ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(name, cnt, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset ready", {31'b0, ready}, 32'd0);
        chk("reset read_data", read_data, 32'd0);
        chk("reset misaligned", {31'b0, misaligned}, 32'd0);
        reset = 1'b0;
        wait_ready("clear latency");

        //  rd   wr   sz uns addr           wd             exp_rd         mis
        add(1'b1, 1'b0, W, 1'b0, 32'h00,      32'h0,         32'h00000000, 1'b0); // 0
        add(1'b1, 1'b0, W, 1'b0, 32'h7C,      32'h0,         32'h00000000, 1'b0); // 1
        add(1'b0, 1'b1, W, 1'b0, 32'h10,      32'h800080F0,  32'h00000000, 1'b0); // 2
        add(1'b1, 1'b0, B, 1'b0, 32'h10,      32'h0,         32'hFFFFFFF0, 1'b0); // 3
        add(1'b1, 1'b0, B, 1'b1, 32'h10,      32'h0,         32'h000000F0, 1'b0); // 4
        add(1'b1, 1'b0, H, 1'b0, 32'h12,      32'h0,         32'hFFFF8000, 1'b0); // 5
        add(1'b1, 1'b0, H, 1'b1, 32'h12,      32'h0,         32'h00008000, 1'b0); // 6
        add(1'b1, 1'b0, W, 1'b1, 32'h10,      32'h0,         32'h800080F0, 1'b0); // 7
        add(1'b0, 1'b1, W, 1'b0, 32'h20,      32'h11223344,  32'h800080F0, 1'b0); // 8
        add(1'b0, 1'b1, B, 1'b0, 32'h21,      32'hFFFFFFAA,  32'h800080F0, 1'b0); // 9
        add(1'b0, 1'b1, H, 1'b0, 32'h22,      32'h1234BEEF,  32'h800080F0, 1'b0); // 10
        add(1'b1, 1'b0, W, 1'b0, 32'h20,      32'h0,         32'hBEEFAA44, 1'b0); // 11
        add(1'b1, 1'b0, B, 1'b0, 32'h23,      32'h0,         32'hFFFFFFBE, 1'b0); // 12
        add(1'b1, 1'b0, B, 1'b1, 32'h21,      32'h0,         32'h000000AA, 1'b0); // 13
        add(1'b1, 1'b0, H, 1'b0, 32'h20,      32'h0,         32'hFFFFAA44, 1'b0); // 14
        add(1'b0, 1'b1, W, 1'b0, 32'h04,      32'hCAFEF00D,  32'hFFFFAA44, 1'b0); // 15
        add(1'b1, 1'b0, W, 1'b0, 32'h05,      32'h0,         32'hFFFFAA44, 1'b1); // 16
        add(1'b0, 1'b1, H, 1'b0, 32'h03,      32'h0000FFFF,  32'hFFFFAA44, 1'b1); // 17
        add(1'b1, 1'b0, X, 1'b0, 32'h00,      32'h0,         32'hFFFFAA44, 1'b1); // 18
        add(1'b0, 1'b1, X, 1'b0, 32'h04,      32'h0,         32'hFFFFAA44, 1'b1); // 19
        add(1'b0, 1'b0, W, 1'b0, 32'h00,      32'h0,         32'hFFFFAA44, 1'b0); // 20
        add(1'b1, 1'b0, W, 1'b0, 32'h04,      32'h0,         32'hCAFEF00D, 1'b0); // 21
        add(1'b1, 1'b0, H, 1'b1, 32'h06,      32'h0,         32'h0000CAFE, 1'b0); // 22
        add(1'b1, 1'b0, H, 1'b0, 32'h06,      32'h0,         32'hFFFFCAFE, 1'b0); // 23
        add(1'b1, 1'b0, B, 1'b0, 32'h04,      32'h0,         32'h0000000D, 1'b0); // 24
        add(1'b0, 1'b1, W, 1'b0, 32'h08,      32'h12345678,  32'h0000000D, 1'b0); // 25
        add(1'b1, 1'b1, W, 1'b0, 32'h08,      32'hDEADBEEF,  32'h12345678, 1'b0); // 26
        add(1'b1, 1'b0, W, 1'b0, 32'h08,      32'h0,         32'hDEADBEEF, 1'b0); // 27
        add(1'b0, 1'b1, W, 1'b0, 32'h80,      32'h55AA55AA,  32'hDEADBEEF, 1'b0); // 28
        add(1'b1, 1'b0, W, 1'b0, 32'h00,      32'h0,         32'h55AA55AA, 1'b0); // 29
        add(1'b1, 1'b0, W, 1'b0, 32'hFFFFFF90, 32'h0,        32'h800080F0, 1'b0); // 30
        add(1'b1, 1'b0, H, 1'b0, 32'h11,      32'h0,         32'h800080F0, 1'b1); // 31
        add(1'b1, 1'b0, B, 1'b0, 32'h11,      32'h0,         32'hFFFFFF80, 1'b0); // 32

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset in the middle of a clear, with requests issued during CLEAR.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                mem_write = 1'b1; size = W; address = 32'h00; write_data = 32'h77777777;
            end else begin
                drive_idle();
            end
            @(posedge clk); #1;
            chk($sformatf("clear1 cyc%0d ready", c), {31'b0, ready}, 32'd0);
        end
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midclear reset ready", {31'b0, ready}, 32'd0);
        chk("midclear reset read_data", read_data, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            case (c)
                2: begin mem_write = 1'b1; size = W; address = 32'h00; write_data = 32'h77777777; end
                3: begin mem_read = 1'b1; size = W; address = 32'h10; end
                4: begin mem_read = 1'b1; size = W; address = 32'h05; end
                default: drive_idle();
            endcase
            @(posedge clk); #1;
            chk($sformatf("clear2 cyc%0d read_data", c), read_data, 32'd0);
            chk($sformatf("clear2 cyc%0d misaligned", c), {31'b0, misaligned}, 32'd0);
        end
        drive_idle();
        // 8 cycles already elapsed; 24 more until ready.
        begin
            int cnt;
            cnt = 8;
            while (!ready && cnt < 100) begin
                @(posedge clk); #1;
                cnt++;
            end
            chk("restart clear latency", cnt, 32);
        end
        begin
            vec_t v;
            v = '{rd: 1'b1, wr: 1'b0, sz: W, uns: 1'b0, addr: 32'h00, wd: 32'h0,
                  exp_rd: 32'h00000000, exp_mis: 1'b0};
            apply(v, 100);
            v.addr = 32'h10;
            apply(v, 101);
            v.addr = 32'h20;
            apply(v, 102);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
